// File: rtl/noc_packetizer_if.sv
// Bus bundle between a processing element, the packetizer and the router local port.
// The slave modport is the packetizer's view; master is the PE/router side.
interface noc_packetizer_if #(
    parameter int DATA_W  = 32,
    parameter int VC_NUM  = 2,
    parameter int ID_X_W  = 2,
    parameter int ID_Y_W  = 2,
    parameter int MAX_LEN = 8
);
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FLIT_W = 2 + VC_W + DATA_W;

    logic              msg_valid;
    logic              msg_ready;
    logic [ID_X_W-1:0] msg_dst_x;
    logic [ID_Y_W-1:0] msg_dst_y;
    logic [LEN_W-1:0]  msg_len;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data;
    logic              flit_valid;
    logic              flit_ready;
    logic [VC_NUM-1:0] vc_ready;
    logic [FLIT_W-1:0] flit;

    modport master (
        output msg_valid, msg_dst_x, msg_dst_y, msg_len, data_valid, data, flit_ready, vc_ready,
        input  msg_ready, data_ready, flit_valid, flit
    );

    modport slave (
        input  msg_valid, msg_dst_x, msg_dst_y, msg_len, data_valid, data, flit_ready, vc_ready,
        output msg_ready, data_ready, flit_valid, flit
    );
endinterface

// File: rtl/noc_packetizer.sv
// Local injection interface: serialises a descriptor plus payload words into
// head/body/tail flits on a round-robin selected virtual channel.
module noc_packetizer #(
    parameter int DATA_W  = 32,
    parameter int VC_NUM  = 2,
    parameter int ID_X_W  = 2,
    parameter int ID_Y_W  = 2,
    parameter int MAX_LEN = 8
) (
    input  logic              noc_clk,
    input  logic              noc_rst_n,
    input  logic [ID_X_W-1:0] id_x,
    input  logic [ID_Y_W-1:0] id_y,
    noc_packetizer_if.slave   bus,
    output logic              busy
);
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FLIT_W = 2 + VC_W + DATA_W;
    localparam int HDR_W  = 2 * (ID_X_W + ID_Y_W) + LEN_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [1:0] TY_HEAD   = 2'b00;
    localparam logic [1:0] TY_BODY   = 2'b01;
    localparam logic [1:0] TY_TAIL   = 2'b10;
    localparam logic [1:0] TY_SINGLE = 2'b11;

    if (DATA_W < HDR_W) begin : g_hdr_width_chk
        $error("noc_packetizer: DATA_W too narrow for head flit fields");
    end

    logic [1:0]        state_q, state_d;
    logic [ID_X_W-1:0] dst_x_q, dst_x_d;
    logic [ID_Y_W-1:0] dst_y_q, dst_y_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [VC_W-1:0]   rr_q, rr_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              flit_valid_q, flit_valid_d;

    logic              slot_free;
    logic              msg_ready;
    logic              data_ready;
    logic              vc_found;
    logic [VC_W-1:0]   vc_sel;
    logic [VC_W-1:0]   rr_next;
    logic [LEN_W-1:0]  msg_len_sat;
    logic [ID_X_W-1:0] hdr_dst_x;
    logic [ID_Y_W-1:0] hdr_dst_y;
    logic [LEN_W-1:0]  hdr_len;
    logic [DATA_W-1:0] hdr_payload;
    logic              load_head;

    assign slot_free   = !flit_valid_q || bus.flit_ready;
    assign msg_ready   = noc_rst_n && (state_q == ST_IDLE);
    assign data_ready  = (state_q == ST_BODY) && slot_free && bus.vc_ready[vc_q];
    assign msg_len_sat = (bus.msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.msg_len;

    // First ready VC at or above the round-robin pointer, with wrap.
    always_comb begin
        int idx;
        idx      = 0;
        vc_found = 1'b0;
        vc_sel   = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(rr_q) + i) % VC_NUM;
            if (!vc_found && bus.vc_ready[idx]) begin
                vc_found = 1'b1;
                vc_sel   = VC_W'(idx);
            end
        end
        rr_next = VC_W'((int'(vc_sel) + 1) % VC_NUM);
    end

    // In IDLE the head is built straight from the descriptor so it can leave next cycle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            hdr_dst_x = bus.msg_dst_x;
            hdr_dst_y = bus.msg_dst_y;
            hdr_len   = msg_len_sat;
        end else begin
            hdr_dst_x = dst_x_q;
            hdr_dst_y = dst_y_q;
            hdr_len   = len_q;
        end
        hdr_payload            = '0;
        hdr_payload[HDR_W-1:0] = {hdr_len, id_y, id_x, hdr_dst_y, hdr_dst_x};
    end

    always_comb begin
        state_d      = state_q;
        dst_x_d      = dst_x_q;
        dst_y_d      = dst_y_q;
        len_d        = len_q;
        rem_d        = rem_q;
        vc_d         = vc_q;
        rr_d         = rr_q;
        flit_d       = flit_q;
        flit_valid_d = flit_valid_q;
        load_head    = 1'b0;

        if (flit_valid_q && bus.flit_ready) begin
            flit_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.msg_valid && msg_ready) begin
                    dst_x_d = bus.msg_dst_x;
                    dst_y_d = bus.msg_dst_y;
                    len_d   = msg_len_sat;
                    state_d = ST_HEAD;
                    load_head = vc_found && slot_free;
                end
            end
            ST_HEAD: begin
                load_head = vc_found && slot_free;
            end
            ST_BODY: begin
                if (bus.data_valid && data_ready) begin
                    flit_d       = {(rem_q == LEN_W'(1)) ? TY_TAIL : TY_BODY, vc_q, bus.data};
                    flit_valid_d = 1'b1;
                    rem_d        = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_head) begin
            flit_d       = {(hdr_len == '0) ? TY_SINGLE : TY_HEAD, vc_sel, hdr_payload};
            flit_valid_d = 1'b1;
            vc_d         = vc_sel;
            rr_d         = rr_next;
            rem_d        = hdr_len;
            state_d      = (hdr_len == '0) ? ST_IDLE : ST_BODY;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q      <= ST_IDLE;
            dst_x_q      <= '0;
            dst_y_q      <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            vc_q         <= '0;
            rr_q         <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_x_q      <= dst_x_d;
            dst_y_q      <= dst_y_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            vc_q         <= vc_d;
            rr_q         <= rr_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
        end
    end

    assign bus.msg_ready  = msg_ready;
    assign bus.data_ready = data_ready;
    assign bus.flit_valid = flit_valid_q;
    assign bus.flit       = flit_q;
    assign busy           = (state_q != ST_IDLE) || flit_valid_q;
endmodule
